// File: rtl/uart_apb_pkg.sv
// Shared constants for the UART16550 APB host: FSM encodings, register map, bus widths.
package uart_apb_pkg;

    localparam int APB_DATA_W   = 32;
    localparam int LCR_DLAB_BIT = 7;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam logic [2:0] ADDR_RHR_THR = 3'd0;
    localparam logic [2:0] ADDR_IER     = 3'd1;
    localparam logic [2:0] ADDR_ISR_FCR = 3'd2;
    localparam logic [2:0] ADDR_LCR     = 3'd3;
    localparam logic [2:0] ADDR_MCR     = 3'd4;
    localparam logic [2:0] ADDR_LSR     = 3'd5;
    localparam logic [2:0] ADDR_MSR     = 3'd6;
    localparam logic [2:0] ADDR_SPR     = 3'd7;

    // Aliases that apply while LCR[DLAB] is set
    localparam logic [2:0] ADDR_DLL = 3'd0;
    localparam logic [2:0] ADDR_DLM = 3'd1;
    localparam logic [2:0] ADDR_PSD = 3'd5;

endpackage

// File: rtl/uart_apb_cmd_fifo.sv
// Synchronous command queue; in_ready is a registered "not full" so it can drive cmd_ready directly.
module uart_apb_cmd_fifo
    import uart_apb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             in_ready
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             empty_q, empty_d;
    logic             ready_q, ready_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);
        ready_d = (count_d != (PTR_W+1)'(DEPTH));
    end

    always_ff @(posedge PCLK) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            ready_q  <= ready_d;
        end
    end

    assign rdata    = mem_q[rd_ptr_q];
    assign empty    = empty_q;
    assign in_ready = ready_q;

endmodule

// File: rtl/uart_apb_host.sv
// APB initiator for the UART16550 register file: queued commands in, one-deep response slot out.
// state  | meaning
// IDLE   | no transfer; waits for a queued command and a free response slot
// SETUP  | PSELx=1, PENABLE=0, address/control driven from the popped command
// ACCESS | PENABLE=1, waiting for PREADY or the timeout
module uart_apb_host
    import uart_apb_pkg::*;
#(
    parameter int ADDR_W         = 3,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [APB_DATA_W-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [APB_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic [ADDR_W-1:0]     PADDR,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [APB_DATA_W-1:0] PWDATA,
    input  logic [APB_DATA_W-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int CMD_W = 1 + ADDR_W + APB_DATA_W;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [1:0]            state_q, state_d;
    logic [ADDR_W-1:0]     paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [APB_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_error_q, rsp_error_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic             fifo_push, fifo_pop, fifo_empty, fifo_ready;
    logic [CMD_W-1:0] fifo_head;
    logic             head_write;
    logic [ADDR_W-1:0] head_addr;
    logic [APB_DATA_W-1:0] head_data;
    logic             start_ok;

    assign fifo_push  = cmd_valid & fifo_ready;
    assign head_write = fifo_head[CMD_W-1];
    assign head_addr  = fifo_head[CMD_W-2 -: ADDR_W];
    assign head_data  = fifo_head[APB_DATA_W-1:0];
    assign start_ok   = !fifo_empty && (!rsp_valid_q || rsp_ready);

    uart_apb_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .wdata    ({cmd_write, cmd_addr, cmd_wdata}),
        .rdata    (fifo_head),
        .empty    (fifo_empty),
        .in_ready (fifo_ready)
    );

    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = rsp_valid_q & ~rsp_ready;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;
        fifo_pop      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) fifo_pop = 1'b1;
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    rsp_valid_d   = 1'b1;
                    rsp_error_d   = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    if (start_ok) begin
                        fifo_pop = 1'b1;
                    end else begin
                        state_d   = ST_IDLE;
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                    end
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_valid_d   = 1'b1;
                    rsp_error_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    state_d       = ST_IDLE;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase

        // Every SETUP entry pops the head and latches it onto the bus
        if (fifo_pop) begin
            state_d   = ST_SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            cnt_d     = '0;
            paddr_d   = head_addr;
            pwrite_d  = head_write;
            if (head_write) pwdata_d = head_data;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q       <= ST_IDLE;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = fifo_ready;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;
    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign PSELx       = psel_q;
    assign PENABLE     = penable_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule
